// File: rtl/sw_pkg.sv
// -----------------------------------------------------------------------------
// sw_pkg
// Shared constants for the slide-switch conditioning path.
//   SW_WIDTH        : number of board slide switches
//   DB_CNT_MAX_HW   : stable cycles before accepting a level (10 ms at 100 MHz)
//   DB_CNT_MAX_SIM  : short debounce count for simulation
//   SYNC_STAGES_DEF : default synchroniser depth
//   db_cnt_w()      : width of a counter that must hold 0..cnt_max
// No ports (package).
// -----------------------------------------------------------------------------
package sw_pkg;

   localparam int SW_WIDTH        = 16;
   localparam int DB_CNT_MAX_HW   = 1000000;
   localparam int DB_CNT_MAX_SIM  = 4;
   localparam int SYNC_STAGES_DEF = 2;

   function automatic int db_cnt_w(input int cnt_max);
      return $clog2(cnt_max + 1);
   endfunction

endpackage

// File: rtl/sw_debounce_bit.sv
// -----------------------------------------------------------------------------
// sw_debounce_bit
// One switch channel: synchroniser chain -> stability counter -> level register
// with registered one-cycle rise/fall strobes.
// Optional feature macro: SW_DEBOUNCE_TOGGLE_EN adds tgl_o, a level that flips
// on every accepted rising edge.
// Ports:
//   clk    : system clock
//   rst_n  : asynchronous active-low reset, clears every flop
//   sw_i   : raw switch level, asynchronous to clk
//   db_o   : debounced level
//   rise_o : one-cycle pulse when db_o goes 0->1
//   fall_o : one-cycle pulse when db_o goes 1->0
//   tgl_o  : (SW_DEBOUNCE_TOGGLE_EN only) toggle latch driven by rise
// -----------------------------------------------------------------------------
module sw_debounce_bit
   import sw_pkg::*;
#(
   parameter int SYNC_STAGES = SYNC_STAGES_DEF,
   parameter int CNT_MAX     = DB_CNT_MAX_HW
) (
   input  logic clk,
   input  logic rst_n,
   input  logic sw_i,
   output logic db_o,
   output logic rise_o,
   output logic fall_o
`ifdef SW_DEBOUNCE_TOGGLE_EN
  ,output logic tgl_o
`endif
);

   localparam int            CW       = db_cnt_w(CNT_MAX);
   localparam logic [CW-1:0] CNT_LAST = CW'(CNT_MAX - 1);

   logic [SYNC_STAGES-1:0] sync_q;
   logic [CW-1:0]          cnt_q, cnt_d;
   logic                   db_q, db_d;
   logic                   rise_q, rise_d;
   logic                   fall_q, fall_d;
   logic                   s;

   assign s = sync_q[SYNC_STAGES-1];

   // Any cycle where the synchronised input agrees with the accepted level
   // restarts the count, so a bounce anywhere in the window costs a full wait.
   always_comb begin
      cnt_d  = '0;
      db_d   = db_q;
      rise_d = 1'b0;
      fall_d = 1'b0;
      if (s != db_q) begin
         if (cnt_q == CNT_LAST) begin
            db_d   = s;
            rise_d = s;
            fall_d = ~s;
         end else begin
            cnt_d = cnt_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_q <= '0;
         cnt_q  <= '0;
         db_q   <= 1'b0;
         rise_q <= 1'b0;
         fall_q <= 1'b0;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], sw_i};
         cnt_q  <= cnt_d;
         db_q   <= db_d;
         rise_q <= rise_d;
         fall_q <= fall_d;
      end
   end

   assign db_o   = db_q;
   assign rise_o = rise_q;
   assign fall_o = fall_q;

`ifdef SW_DEBOUNCE_TOGGLE_EN
   logic tgl_q;

   // Flips on the same edge that raises rise_q, so the latch and the strobe
   // change together.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tgl_q <= 1'b0;
      end else begin
         tgl_q <= tgl_q ^ rise_d;
      end
   end

   assign tgl_o = tgl_q;
`endif

endmodule

// File: rtl/sw_debounce.sv
// -----------------------------------------------------------------------------
// sw_debounce
// Conditions the board slide switches: each of WIDTH inputs is synchronised
// and debounced independently; outputs are a clean level bus plus per-bit
// rise/fall strobes.
// Optional feature macro: SW_DEBOUNCE_TOGGLE_EN adds sw_tgl, a per-bit latch
// that flips on every press.
// Ports:
//   clk     : system clock (100 MHz on board)
//   rst_n   : asynchronous active-low reset
//   sw      : raw switch levels, asynchronous to clk
//   sw_db   : debounced, registered levels
//   sw_rise : one-cycle pulse per bit on 0->1 of sw_db
//   sw_fall : one-cycle pulse per bit on 1->0 of sw_db
//   sw_tgl  : (SW_DEBOUNCE_TOGGLE_EN only) per-bit press toggle, resets to 0
// -----------------------------------------------------------------------------
module sw_debounce
   import sw_pkg::*;
#(
   parameter int WIDTH       = SW_WIDTH,
   parameter int SYNC_STAGES = SYNC_STAGES_DEF,
   parameter int CNT_MAX     = DB_CNT_MAX_HW
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] sw,
   output logic [WIDTH-1:0] sw_db,
   output logic [WIDTH-1:0] sw_rise,
   output logic [WIDTH-1:0] sw_fall
`ifdef SW_DEBOUNCE_TOGGLE_EN
  ,output logic [WIDTH-1:0] sw_tgl
`endif
);

   for (genvar i = 0; i < WIDTH; i++) begin : g_ch
      sw_debounce_bit #(
         .SYNC_STAGES (SYNC_STAGES),
         .CNT_MAX     (CNT_MAX)
      ) u_bit (
         .clk    (clk),
         .rst_n  (rst_n),
         .sw_i   (sw[i]),
         .db_o   (sw_db[i]),
         .rise_o (sw_rise[i]),
         .fall_o (sw_fall[i])
`ifdef SW_DEBOUNCE_TOGGLE_EN
        ,.tgl_o  (sw_tgl[i])
`endif
      );
   end

endmodule

// File: tb/tb_sw_debounce.sv
// -----------------------------------------------------------------------------
// tb_sw_debounce
// Directed bench for sw_debounce with CNT_MAX=4, SYNC_STAGES=2. Inputs change
// 1 ns after a rising edge; outputs are sampled 1 ns after each rising edge.
// With those settings a new level first sampled on tick 1 appears on sw_db
// (with its strobe) on tick 6.
// Optional feature macro: SW_DEBOUNCE_TOGGLE_EN enables the sw_tgl checks.
// -----------------------------------------------------------------------------
module tb_sw_debounce;
   import sw_pkg::*;

   localparam int W  = SW_WIDTH;
   localparam int CM = DB_CNT_MAX_SIM;
   localparam int SS = SYNC_STAGES_DEF;

   logic         clk = 1'b0;
   logic         rst_n;
   logic [W-1:0] sw;
   logic [W-1:0] sw_db;
   logic [W-1:0] sw_rise;
   logic [W-1:0] sw_fall;
`ifdef SW_DEBOUNCE_TOGGLE_EN
   logic [W-1:0] sw_tgl;
`endif

   int n_checks = 0;
   int n_pass   = 0;

   sw_debounce #(
      .WIDTH       (W),
      .SYNC_STAGES (SS),
      .CNT_MAX     (CM)
   ) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .sw      (sw),
      .sw_db   (sw_db),
      .sw_rise (sw_rise),
      .sw_fall (sw_fall)
`ifdef SW_DEBOUNCE_TOGGLE_EN
     ,.sw_tgl  (sw_tgl)
`endif
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      int rises;
      int falls;

      // 1: sw high through reset, release between edges
      rst_n = 1'b0;
      sw    = 16'hFFFF;
      #2;
      check("rst_async_db", sw_db, 0);
      repeat (3) tick();
      check("rst_db",   sw_db,   0);
      check("rst_rise", sw_rise, 0);
      check("rst_fall", sw_fall, 0);
      rst_n = 1'b1;
      for (int k = 1; k <= 5; k++) begin
         tick();
         check("t1_db_wait",   sw_db,   0);
         check("t1_rise_wait", sw_rise, 0);
      end
      tick();
      check("t1_db",   sw_db,   16'hFFFF);
      check("t1_rise", sw_rise, 16'hFFFF);
      check("t1_fall", sw_fall, 0);
      tick();
      check("t1_rise_end", sw_rise, 0);
      check("t1_db_hold",  sw_db,   16'hFFFF);

      sw = 16'h0000;
      repeat (10) tick();
      check("t2_init_db", sw_db, 0);

      // 2: 3-cycle glitch on bit 0 must be rejected
      sw = 16'h0001;
      for (int k = 0; k < 3; k++) begin
         tick();
         check("t2_db",   sw_db,             0);
         check("t2_strb", sw_rise | sw_fall, 0);
      end
      sw = 16'h0000;
      for (int k = 0; k < 10; k++) begin
         tick();
         check("t2_db",   sw_db,             0);
         check("t2_strb", sw_rise | sw_fall, 0);
      end

      // 3: bit 3 chatters, then holds 1
      rises = 0;
      falls = 0;
      for (int i = 0; i < 10; i++) begin
         sw[3] = (i % 2 == 0);
         tick();
         rises += int'(sw_rise[3]);
         falls += int'(sw_fall[3]);
      end
      sw[3] = 1'b1;
      for (int k = 1; k <= 5; k++) begin
         tick();
         check("t3_db_wait", sw_db[3], 0);
         rises += int'(sw_rise[3]);
      end
      tick();
      check("t3_db", sw_db[3], 1);
      rises += int'(sw_rise[3]);
      repeat (6) begin
         tick();
         rises += int'(sw_rise[3]);
         falls += int'(sw_fall[3]);
      end
      check("t3_rise_cnt", rises, 1);
      check("t3_fall_cnt", falls, 0);

      // 4: simultaneous rise and fall on different bits
      sw = 16'h00F0;
      repeat (10) tick();
      check("t4_init_db", sw_db, 16'h00F0);
      sw = 16'h0F00;
      for (int k = 1; k <= 5; k++) begin
         tick();
         check("t4_db_wait",   sw_db,             16'h00F0);
         check("t4_strb_wait", sw_rise | sw_fall, 0);
      end
      tick();
      check("t4_db",   sw_db,   16'h0F00);
      check("t4_rise", sw_rise, 16'h0F00);
      check("t4_fall", sw_fall, 16'h00F0);
      tick();
      check("t4_strb_end", sw_rise | sw_fall, 0);

      // 5: async reset after two counted mismatches on bit 5
      sw = 16'h0F20;
      repeat (4) tick();
      check("t5_pre_db", sw_db, 16'h0F00);
      #2;
      rst_n = 1'b0;
      #1;
      check("t5_rst_db",   sw_db,   0);
      check("t5_rst_rise", sw_rise, 0);
      check("t5_rst_fall", sw_fall, 0);
      tick();
      check("t5_rst_hold", sw_db, 0);
      rst_n = 1'b1;
      for (int k = 1; k <= 5; k++) begin
         tick();
         check("t5_db_wait",   sw_db,   0);
         check("t5_rise_wait", sw_rise, 0);
      end
      tick();
      check("t5_db",   sw_db,   16'h0F20);
      check("t5_rise", sw_rise, 16'h0F20);
      check("t5_fall", sw_fall, 0);
      tick();
      check("t5_rise_end", sw_rise, 0);

`ifdef SW_DEBOUNCE_TOGGLE_EN
      // 6: toggle latch on bit 7, three presses
      check("t6_tgl_init", sw_tgl, 16'h0F20);
      for (int p = 0; p < 3; p++) begin
         logic exp_old;
         logic exp_new;
         exp_old = (p % 2 == 1);
         exp_new = ~exp_old;
         sw[7] = 1'b1;
         for (int k = 1; k <= 5; k++) begin
            tick();
            check("t6_tgl_wait", sw_tgl[7], exp_old);
         end
         tick();
         check("t6_tgl",  sw_tgl[7],  exp_new);
         check("t6_rise", sw_rise[7], 1);
         repeat (4) tick();
         sw[7] = 1'b0;
         repeat (10) begin
            tick();
            check("t6_tgl_rel", sw_tgl[7], exp_new);
         end
      end
`endif

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
